// File: rtl/riscv_next_pc_gen.sv
// rtl/riscv_next_pc_gen.sv - fetch PC generator with in-order prediction-record FIFO
// Optional statistics counters enabled by defining RISCV_NEXT_PC_STATS_EN.
module riscv_next_pc_gen #(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  enable,
    input  logic                  i_stall,
    output logic [ADDR_WIDTH-1:0] o_pm_pc,
    input  logic                  i_inject,
    input  logic [ADDR_WIDTH-1:0] i_inject_addr,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
    input  logic                  i_retire,
    output logic                  o_fetch_valid,
    output logic                  o_pred_valid,
    output logic                  o_pred_taken,
    output logic [ADDR_WIDTH-1:0] o_pred_target,
    output logic                  o_full
`ifdef RISCV_NEXT_PC_STATS_EN
    ,
    output logic [31:0]           o_inject_count,
    output logic [31:0]           o_redirect_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  taken_q  [DEPTH];
    logic                  taken_d  [DEPTH];
    logic [ADDR_WIDTH-1:0] target_q [DEPTH];
    logic [ADDR_WIDTH-1:0] target_d [DEPTH];

    logic                  en, full, issue, pop, redir;
    logic [ADDR_WIDTH-1:0] next_pc;

    // Reset also gates enable so o_fetch_valid stays low while nreset is asserted.
    always_comb begin
        en       = enable & nreset;
        full     = (count_q == CW'(DEPTH));
        redir    = en & i_redirect;
        issue    = en & ~i_stall & ~i_redirect & (~full | i_retire);
        pop      = en & i_retire & ~i_redirect & (count_q != '0);
        next_pc  = i_inject ? i_inject_addr : pc_q + ADDR_WIDTH'(4);

        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        taken_d  = taken_q;
        target_d = target_q;

        if (redir) begin
            pc_d     = i_redirect_addr;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d               = next_pc;
                taken_d[wr_ptr_q]  = i_inject;
                target_d[wr_ptr_q] = next_pc;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(issue) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                taken_q[i]  <= 1'b0;
                target_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign o_pm_pc       = pc_q;
    assign o_fetch_valid = issue;
    assign o_pred_valid  = (count_q != '0);
    assign o_pred_taken  = taken_q[rd_ptr_q];
    assign o_pred_target = target_q[rd_ptr_q];
    assign o_full        = full;

`ifdef RISCV_NEXT_PC_STATS_EN
    logic [31:0] inj_cnt_q, inj_cnt_d, red_cnt_q, red_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        inj_cnt_d = inj_cnt_q;
        red_cnt_d = red_cnt_q;
        if (issue && i_inject && inj_cnt_q != 32'hFFFF_FFFF) begin
            inj_cnt_d = inj_cnt_q + 32'd1;
        end
        if (redir && red_cnt_q != 32'hFFFF_FFFF) begin
            red_cnt_d = red_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            inj_cnt_q <= '0;
            red_cnt_q <= '0;
        end else begin
            inj_cnt_q <= inj_cnt_d;
            red_cnt_q <= red_cnt_d;
        end
    end

    assign o_inject_count   = inj_cnt_q;
    assign o_redirect_count = red_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_next_pc_gen.sv
// tb/tb_riscv_next_pc_gen.sv - scoreboard bench for riscv_next_pc_gen
// Honours RISCV_NEXT_PC_STATS_EN when defined.
module tb_riscv_next_pc_gen;

    localparam int          AW       = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    typedef struct packed {
        logic        taken;
        logic [63:0] target;
    } rec_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        enable, i_stall, i_inject, i_redirect, i_retire;
    logic [63:0] i_inject_addr, i_redirect_addr;
    logic [63:0] o_pm_pc, o_pred_target;
    logic        o_fetch_valid, o_pred_valid, o_pred_taken, o_full;
`ifdef RISCV_NEXT_PC_STATS_EN
    logic [31:0] o_inject_count, o_redirect_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_next_pc_gen #(.ADDR_WIDTH(AW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall),
        .o_pm_pc(o_pm_pc), .i_inject(i_inject), .i_inject_addr(i_inject_addr),
        .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr), .i_retire(i_retire),
        .o_fetch_valid(o_fetch_valid), .o_pred_valid(o_pred_valid),
        .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target), .o_full(o_full)
`ifdef RISCV_NEXT_PC_STATS_EN
        , .o_inject_count(o_inject_count), .o_redirect_count(o_redirect_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch PC plus a queue of outstanding prediction records.
    logic [63:0] m_pc;
    rec_t        m_q[$];
    logic [31:0] m_inj, m_red;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_pc  <= RESET_PC;
            m_q.delete();
            m_inj <= 0;
            m_red <= 0;
        end else if (enable) begin
            if (i_redirect) begin
                m_pc <= i_redirect_addr;
                m_q.delete();
                if (m_red != 32'hFFFF_FFFF) m_red <= m_red + 1;
            end else begin
                automatic bit can = !i_stall && (m_q.size() < DEPTH || i_retire);
                automatic logic [63:0] nxt = i_inject ? i_inject_addr : m_pc + 64'd4;
                if (i_retire && m_q.size() > 0) void'(m_q.pop_front());
                if (can) begin
                    m_q.push_back('{taken: i_inject, target: nxt});
                    m_pc <= nxt;
                    if (i_inject && m_inj != 32'hFFFF_FFFF) m_inj <= m_inj + 1;
                end
            end
        end
    end

    // Monitor: compares DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (nreset) begin
            automatic bit exp_fv = enable && !i_stall && !i_redirect &&
                                   (m_q.size() < DEPTH || i_retire);
            chk("pm_pc", o_pm_pc, m_pc);
            chk("fetch_valid", 64'(o_fetch_valid), 64'(exp_fv));
            chk("pred_valid", 64'(o_pred_valid), 64'(m_q.size() > 0));
            chk("full", 64'(o_full), 64'(m_q.size() == DEPTH));
            if (o_pred_valid && m_q.size() > 0) begin
                chk("pred_taken", 64'(o_pred_taken), 64'(m_q[0].taken));
                chk("pred_target", o_pred_target, m_q[0].target);
            end
`ifdef RISCV_NEXT_PC_STATS_EN
            chk("inject_count", 64'(o_inject_count), 64'(m_inj));
            chk("redirect_count", 64'(o_redirect_count), 64'(m_red));
`endif
        end
    end

    task automatic drive(input logic en, input logic st, input logic inj, input logic [63:0] ia,
                         input logic rd, input logic [63:0] ra, input logic rt);
        enable = en; i_stall = st; i_inject = inj; i_inject_addr = ia;
        i_redirect = rd; i_redirect_addr = ra; i_retire = rt;
        @(posedge clk);
        #2;
    endtask

    initial begin
        nreset = 1'b0;
        enable = 1'b1; i_stall = 1'b0; i_inject = 1'b0; i_redirect = 1'b0; i_retire = 1'b0;
        i_inject_addr = '0; i_redirect_addr = '0;
        #7;
        chk("reset_pm_pc", o_pm_pc, RESET_PC);
        chk("reset_pred_valid", 64'(o_pred_valid), 64'd0);
        chk("reset_full", 64'(o_full), 64'd0);
        chk("reset_fetch_valid", 64'(o_fetch_valid), 64'd0);
        chk("reset_pred_taken", 64'(o_pred_taken), 64'd0);
        chk("reset_pred_target", o_pred_target, 64'd0);
        @(posedge clk);
        #2 nreset = 1'b1;

        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);           // 0 -> 4 -> 8 -> 12
        chk("seq_pc12", o_pm_pc, 64'd12);
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("seq_pc20", o_pm_pc, 64'd20);
        drive(1, 0, 1, 64'd44, 0, 0, 1);
        chk("inject_pc44", o_pm_pc, 64'd44);
        repeat (6) drive(1, 0, 0, 0, 0, 0, 0);            // fill and hold
        chk("full_set", 64'(o_full), 64'd1);
        drive(1, 0, 0, 0, 0, 0, 1);                       // push+pop while full
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 64'h100, 1);                 // redirect overrides stall
        chk("redirect_pc", o_pm_pc, 64'h100);
        chk("redirect_flush", 64'(o_pred_valid), 64'd0);
        drive(1, 1, 0, 0, 0, 0, 1);                       // retire while empty
        drive(1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("wrap_pc", o_pm_pc, 64'd0);
        drive(0, 0, 1, 64'h80, 1, 64'h200, 1);            // disabled: all held

        for (int n = 0; n < 1500; n++) begin
            automatic logic [63:0] ia = {$urandom, $urandom} & ~64'h3;
            automatic logic [63:0] ra = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                        : ({$urandom, $urandom} & ~64'h3);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 3) == 0, ia, $urandom_range(0, 19) == 0, ra,
                  $urandom_range(0, 1) == 0);
        end

        drive(1, 0, 1, 64'h40, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1 nreset = 1'b0;                                 // async mid-cycle reset
        #1;
        chk("midreset_pm_pc", o_pm_pc, RESET_PC);
        chk("midreset_pred_valid", 64'(o_pred_valid), 64'd0);
        chk("midreset_fetch_valid", 64'(o_fetch_valid), 64'd0);
`ifdef RISCV_NEXT_PC_STATS_EN
        chk("midreset_inj_cnt", 64'(o_inject_count), 64'd0);
        chk("midreset_red_cnt", 64'(o_redirect_count), 64'd0);
`endif
        @(posedge clk);
        #2 nreset = 1'b1;
        drive(1, 0, 1, 64'h30, 0, 0, 1);
        drive(1, 0, 1, 64'h50, 0, 0, 1);
        drive(1, 0, 0, 0, 1, 64'h10, 0);
`ifdef RISCV_NEXT_PC_STATS_EN
        chk("stats_inj2", 64'(o_inject_count), 64'd2);
        chk("stats_red1", 64'(o_redirect_count), 64'd1);
`endif
        repeat (3) drive(1, 0, 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
